// File: rtl/alu_multicycle_exec_if.sv
// rtl/alu_multicycle_exec_if.sv - valid/ready operand and result bundle for the execute ALU
interface alu_multicycle_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_multicycle_exec.sv
// rtl/alu_multicycle_exec.sv - execute-stage ALU, single-cycle arith/logic, iterative shifts
module alu_multicycle_exec #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_multicycle_exec_if.slave bus
);
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [4:0] STEP    = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t          state_q, state_d;
    shkind_t         kind_q, kind_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [4:0]      rem_q, rem_d;

    logic [4:0]      shamt;
    logic            is_shift;
    shkind_t         in_kind;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] acc_shifted;
    logic [4:0]      k;

    assign shamt = bus.b[4:0];

    // Shift codes fall through to pass-through here; they only reach this path with shamt==0.
    always_comb begin
        alu_res = bus.a + bus.b;
        case (bus.alu_op)
            OP_SUB:                 alu_res = bus.a - bus.b;
            OP_AND:                 alu_res = bus.a & bus.b;
            OP_OR:                  alu_res = bus.a | bus.b;
            OP_XOR:                 alu_res = bus.a ^ bus.b;
            OP_SLTU:                alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            OP_SLT:                 alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLL, OP_SRL, OP_SRA: alu_res = bus.a;
            default:                ;
        endcase
    end

    always_comb begin
        is_shift = 1'b1;
        in_kind  = SH_LL;
        case (bus.alu_op)
            OP_SLL:  in_kind = SH_LL;
            OP_SRL:  in_kind = SH_RL;
            OP_SRA:  in_kind = SH_RA;
            default: is_shift = 1'b0;
        endcase
    end

    assign k = (rem_q < STEP) ? rem_q : STEP;

    always_comb begin
        case (kind_q)
            SH_RL:   acc_shifted = acc_q >> k;
            SH_RA:   acc_shifted = $signed(acc_q) >>> k;
            default: acc_shifted = acc_q << k;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        result_d = result_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift && shamt != 5'd0) begin
                        acc_d   = bus.a;
                        rem_d   = shamt;
                        kind_d  = in_kind;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_shifted;
                rem_d = rem_q - k;
                if (rem_q == k) begin
                    result_d = acc_shifted;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kind_q   <= SH_LL;
            result_q <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);
endmodule
